// File: rtl/fifo_ctrl_th.sv
// fifo_ctrl_th
// -----------------------------------------------------------------------------
// Per-port synchronous packet-buffer FIFO sitting between the ingress parser
// and the output arbiter. It provides an occupancy count, programmable
// almost-full / almost-empty thresholds, and a registered read port with a
// one-cycle valid strobe. It also has sticky overflow / underflow flags and a
// synchronous flush.
//
// Handshake: a write is taken on a rising edge when wr_en is high and the FIFO
// can accept it. A read is taken when rd_en is high and the FIFO is not empty.
// The word read appears on data_out, with rd_valid high, for exactly the one
// cycle after the accepting edge. There is no ready output: the producer must
// watch full / almost_full, and the consumer must watch empty / almost_empty.
//
// Parameters
//   FIFO_SIZE   number of locations (power of two, >= 2)
//   W_WIDTH     data word width
//   AFULL_LVL   almost_full  when count >= AFULL_LVL  (1..FIFO_SIZE)
//   AEMPTY_LVL  almost_empty when count <= AEMPTY_LVL (0..FIFO_SIZE-1)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   clr           synchronous flush: empties FIFO, clears error flags
//   wr_en         write request, data_in sampled with it
//   data_in       write data
//   rd_en         read request
//   data_out      registered read data (holds between reads)
//   rd_valid      data_out carries a newly read word this cycle
//   full/empty    count == FIFO_SIZE / count == 0
//   almost_full   count >= AFULL_LVL
//   almost_empty  count <= AEMPTY_LVL
//   count         occupancy 0..FIFO_SIZE
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
// -----------------------------------------------------------------------------
module fifo_ctrl_th #(
    parameter int FIFO_SIZE  = 64,
    parameter int W_WIDTH    = 8,
    parameter int AFULL_LVL  = 56,
    parameter int AEMPTY_LVL = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [W_WIDTH-1:0]           data_in,
    input  logic                         rd_en,
    output logic [W_WIDTH-1:0]           data_out,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(FIFO_SIZE):0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(FIFO_SIZE);
    localparam int CW = AW + 1;

    // Storage is deliberately not reset so it can map onto plain RAM.
    logic [W_WIDTH-1:0] mem [FIFO_SIZE];

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [W_WIDTH-1:0] data_out_q, data_out_d;
    logic               rd_valid_q, rd_valid_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               rd_acc;
    logic               wr_acc;

    // Status flags decode the registered count only, so no request input has
    // a combinational path to any output.
    assign full         = (count_q == CW'(FIFO_SIZE));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AFULL_LVL));
    assign almost_empty = (count_q <= CW'(AEMPTY_LVL));

    // A read frees a slot in the same edge, so a write at full is still taken
    // when it pairs with a read. At empty the read is refused (no fall-through).
    assign rd_acc = rd_en & ~empty & ~clr;
    assign wr_acc = wr_en & ~clr & (~full | rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr) begin
            // Flush wins over any request; data_out keeps its last word.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                data_out_d = mem[rd_ptr_q];
                rd_valid_d = 1'b1;
            end

            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            if (wr_en & full & ~rd_acc) begin
                overflow_d = 1'b1;
            end
            if (rd_en & empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl_th.sv
// Testbench for fifo_ctrl_th. The reference model is a data queue plus sticky
// flags. It is updated on every rising edge from the accept rules, and every
// output is sampled 1 time unit after the edge.
module tb_fifo_ctrl_th;

    localparam int N  = 64;
    localparam int AF = 56;
    localparam int AE = 8;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [6:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    // reference model
    logic [7:0] exp_q[$];
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovf;
    logic       m_udf;

    fifo_ctrl_th #(
        .FIFO_SIZE (N),
        .W_WIDTH   (8),
        .AFULL_LVL (AF),
        .AEMPTY_LVL(AE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        exp_q.delete();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // driver: apply inputs, advance one edge, update model, settle
    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
        bit rd_ok;
        bit wr_ok;
        wr_en   = w;
        rd_en   = r;
        clr     = c;
        data_in = d;
        @(posedge clk);
        if (c) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            rd_ok = r && (exp_q.size() > 0);
            wr_ok = w && ((exp_q.size() < N) || rd_ok);
            if (r && !rd_ok) m_udf = 1'b1;
            if (w && !wr_ok) m_ovf = 1'b1;
            m_valid = rd_ok;
            if (rd_ok) m_data = exp_q.pop_front();
            if (wr_ok) exp_q.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow}
            !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: dout=%h v=%b f=%b e=%b af=%b ae=%b cnt=%0d ov=%b un=%b, want 00 0 0 1 0 1 0 0 0",
                     data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < N; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(i));
            checks++;
            if (count !== 7'(i + 1) || full !== (i == N - 1)) begin
                errors++;
                $display("FAIL fill_count: i=%0d count=%0d full=%b, want %0d %b", i, count, full, i + 1, (i == N - 1));
            end
        end
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            checks++;
            if (rd_valid !== 1'b1 || data_out !== 8'(i)) begin
                errors++;
                $display("FAIL drain_data: i=%0d data=%h v=%b, want %h 1", i, data_out, rd_valid, 8'(i));
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (empty !== 1'b1 || count !== 7'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: empty=%b count=%0d v=%b, want 1 0 0", empty, count, rd_valid);
        end
        // pointers wrapped: a fresh word must come back from location 0
        step(1'b1, 1'b0, 1'b0, 8'h77);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (data_out !== 8'h77 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_roundtrip: data=%h v=%b, want 77 1", data_out, rd_valid);
        end
    endtask

    task automatic test_overflow_clr();
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
        step(1'b1, 1'b0, 1'b0, 8'hAA);
        checks++;
        if (overflow !== 1'b1 || count !== 7'd64 || full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: ov=%b count=%0d full=%b, want 1 64 1", overflow, count, full);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: ov=%b, want 1", overflow);
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (count !== 7'd0 || empty !== 1'b1 || overflow !== 1'b0 || data_out !== m_data) begin
            errors++;
            $display("FAIL clr_flush: count=%0d empty=%b ov=%b dout=%h, want 0 1 0 %h", count, empty, overflow, data_out, m_data);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
            checks++;
            if (count !== 7'd64 || full !== 1'b1 || rd_valid !== 1'b1 || data_out !== 8'(i) || overflow !== 1'b0) begin
                errors++;
                $display("FAIL full_rw: i=%0d count=%0d full=%b v=%b data=%h ov=%b, want 64 1 1 %h 0",
                         i, count, full, rd_valid, data_out, 8'(i), overflow);
            end
        end
        for (int k = 0; k < N; k++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            checks++;
            if (data_out !== ((k < 54) ? 8'(10 + k) : 8'(8'h40 + k - 54)) || rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL full_rw_drain: k=%0d data=%h v=%b, want %h 1",
                         k, data_out, rd_valid, (k < 54) ? 8'(10 + k) : 8'(8'h40 + k - 54));
            end
        end
    endtask

    task automatic test_empty_rw();
        step(1'b1, 1'b1, 1'b0, 8'h5C);
        checks++;
        if (rd_valid !== 1'b0 || underflow !== 1'b1 || count !== 7'd1) begin
            errors++;
            $display("FAIL empty_rw: v=%b un=%b count=%0d, want 0 1 1", rd_valid, underflow, count);
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (data_out !== 8'h5C || rd_valid !== 1'b1 || count !== 7'd0) begin
            errors++;
            $display("FAIL empty_rw_read: data=%h v=%b count=%0d, want 5c 1 0", data_out, rd_valid, count);
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clr: un=%b, want 0", underflow);
        end
    endtask

    task automatic test_thresholds();
        for (int i = 1; i <= 60; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(i));
            checks++;
            if (almost_empty !== (i <= AE) || almost_full !== (i >= AF)) begin
                errors++;
                $display("FAIL thresh_up: count=%0d ae=%b af=%b, want %b %b", i, almost_empty, almost_full, (i <= AE), (i >= AF));
            end
        end
        for (int i = 59; i >= 50; i--) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            checks++;
            if (almost_full !== (i >= AF) || count !== 7'(i)) begin
                errors++;
                $display("FAIL thresh_down: count=%0d af=%b, want %0d %b", count, almost_full, i, (i >= AF));
            end
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_random();
        int phase;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            phase = (cyc / 300) % 3;
            step(($urandom_range(0, 99) < ((phase == 0) ? 80 : (phase == 1) ? 20 : 50)),
                 ($urandom_range(0, 99) < ((phase == 0) ? 20 : (phase == 1) ? 80 : 50)),
                 ($urandom_range(0, 199) == 0),
                 8'($urandom_range(0, 255)));
            checks++;
            if (count !== 7'(exp_q.size()) || full !== (exp_q.size() == N) || empty !== (exp_q.size() == 0) ||
                almost_full !== (exp_q.size() >= AF) || almost_empty !== (exp_q.size() <= AE) ||
                rd_valid !== m_valid || data_out !== m_data || overflow !== m_ovf || underflow !== m_udf) begin
                errors++;
                $display("FAIL random: cyc=%0d cnt=%0d/%0d v=%b/%b d=%h/%h ov=%b/%b un=%b/%b f=%b e=%b af=%b ae=%b",
                         cyc, count, exp_q.size(), rd_valid, m_valid, data_out, m_data,
                         overflow, m_ovf, underflow, m_udf, full, empty, almost_full, almost_empty);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
        step(1'b0, 1'b1, 1'b0, 8'h00);
        // rd_en still high, mid-cycle and well away from any clk edge
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow}
            !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: dout=%h v=%b f=%b e=%b af=%b ae=%b cnt=%0d ov=%b un=%b, want 00 0 0 1 0 1 0 0 0",
                     data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow);
        end
        rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h3C);
        checks++;
        if (count !== 7'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_write: count=%0d empty=%b, want 1 0", count, empty);
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (data_out !== 8'h3C || rd_valid !== 1'b1 || count !== 7'd0) begin
            errors++;
            $display("FAIL post_reset_read: data=%h v=%b count=%0d, want 3c 1 0", data_out, rd_valid, count);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;
        model_reset();
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_fill_drain();
        test_overflow_clr();
        test_full_rw();
        test_empty_rw();
        test_thresholds();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
